// File: rtl/mem_io_responder_if.sv
// Load/store bus between the processor core (master) and mem_io_responder (slave).
interface mem_io_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              req;
  logic              wr;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, wr, addr, wdata, input ack, rdata, err);
  modport slave  (input req, wr, addr, wdata, output ack, rdata, err);
endinterface

// File: rtl/mem_io_responder.sv
// Wait-state bus responder backing a data RAM, an LED register and a switch port.
// Define MEM_IO_RESP_ERR_EN to flag unmapped accesses and switch-port writes on err.
module mem_io_responder #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 16,
  parameter int                DEPTH       = 32,
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] LED_ADDR    = 16'h1000,
  parameter logic [ADDR_W-1:0] SW_ADDR     = 16'h3000
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_io_responder_if.slave   bus,
  input  logic [9:0]          sw,
  output logic [9:0]          led
);

  localparam int                CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt;
  logic              wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] ram [DEPTH];

  logic              accept, enter_resp;
  logic              cur_wr;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic              sel_ram, sel_led, sel_sw;
  logic [DATA_W-1:0] read_word;

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (bus.req) next_state = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == '0) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // In IDLE the transaction is being accepted this edge, so decode the live bus;
  // afterwards the latched copy is authoritative.
  always_comb begin
    accept     = (state == IDLE) && bus.req;
    enter_resp = (next_state == RESP);
    cur_wr     = (state == IDLE) ? bus.wr    : wr_q;
    cur_addr   = (state == IDLE) ? bus.addr  : addr_q;
    cur_wdata  = (state == IDLE) ? bus.wdata : wdata_q;
    sel_ram    = (cur_addr < DEPTH_A);
    sel_led    = (cur_addr == LED_ADDR);
    sel_sw     = (cur_addr == SW_ADDR);
    read_word  = '0;
    if (sel_ram)      read_word = ram[cur_addr[IDX_W-1:0]];
    else if (sel_led) read_word = {{(DATA_W-10){1'b0}}, led};
    else if (sel_sw)  read_word = {{(DATA_W-10){1'b0}}, sw};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      bus.ack   <= 1'b0;
      bus.rdata <= '0;
      led       <= '0;
    end else begin
      state   <= next_state;
      bus.ack <= enter_resp;
      if (accept) begin
        wr_q    <= bus.wr;
        addr_q  <= bus.addr;
        wdata_q <= bus.wdata;
        cnt     <= CNT_LOAD;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (enter_resp) begin
        if (cur_wr) begin
          bus.rdata <= '0;
          if (sel_led) led <= cur_wdata[9:0];
        end else begin
          bus.rdata <= read_word;
        end
      end
    end
  end

  // NOTE: RAM contents carry no reset; gating on reset_n keeps an aborted write from landing.
  always_ff @(posedge clk) begin
    if (reset_n && enter_resp && cur_wr && sel_ram)
      ram[cur_addr[IDX_W-1:0]] <= cur_wdata;
  end

`ifdef MEM_IO_RESP_ERR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        bus.err <= 1'b0;
    else if (enter_resp) bus.err <= !(sel_ram || sel_led || sel_sw) || (cur_wr && sel_sw);
    else if (state == RESP) bus.err <= 1'b0;
  end
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench: one responder with two wait states and one with none, sharing clock and reset.
module tb_mem_io_responder;

`ifdef MEM_IO_RESP_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [9:0] sw = '0;
  logic [9:0] led2, led0;
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  mem_io_responder_if bus2 ();
  mem_io_responder_if bus0 ();

  mem_io_responder #(.WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2.slave), .sw(sw), .led(led2)
  );
  mem_io_responder #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .sw(sw), .led(led0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One transaction on the selected responder (sel=1: zero wait states).
  // Returns the values seen in the ack cycle and the edge count from acceptance (inclusive).
  task automatic txn(input logic sel, input logic w, input logic [15:0] a, input logic [15:0] d,
                     output logic [15:0] rd, output logic e, output int lat);
    logic ack_now;
    @(negedge clk);
    if (sel) begin bus0.req = 1'b1; bus0.wr = w; bus0.addr = a; bus0.wdata = d; end
    else     begin bus2.req = 1'b1; bus2.wr = w; bus2.addr = a; bus2.wdata = d; end
    lat = 0;
    ack_now = 1'b0;
    while (!ack_now && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      ack_now = sel ? bus0.ack : bus2.ack;
      if (lat == 1 && !sel && !ack_now) begin
        bus2.addr = ~a; bus2.wdata = ~d; bus2.wr = ~w;
      end
    end
    check("ack_seen", {31'b0, ack_now}, 32'd1);
    rd = sel ? bus0.rdata : bus2.rdata;
    e  = sel ? bus0.err   : bus2.err;
    if (sel) bus0.req = 1'b0; else bus2.req = 1'b0;
    @(posedge clk); #1;
    check("ack_one_cycle", {31'b0, sel ? bus0.ack : bus2.ack}, 32'd0);
    check("err_cleared",   {31'b0, sel ? bus0.err : bus2.err}, 32'd0);
  endtask

  logic [15:0] rd;
  logic        e;
  int          lat;
  int          acks;
  int          k;
  int          ack_edge [3];
  logic [15:0] got [3];

  initial begin
    bus2.req = 1'b0; bus2.wr = 1'b0; bus2.addr = '0; bus2.wdata = '0;
    bus0.req = 1'b0; bus0.wr = 1'b0; bus0.addr = '0; bus0.wdata = '0;

    // Reset, then idle with no requests
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack2",   {31'b0, bus2.ack}, 32'd0);
    check("rst_rdata2", {16'b0, bus2.rdata}, 32'd0);
    check("rst_led2",   {22'b0, led2}, 32'd0);
    check("rst_err2",   {31'b0, bus2.err}, 32'd0);
    check("rst_ack0",   {31'b0, bus0.ack}, 32'd0);
    check("rst_led0",   {22'b0, led0}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    acks = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus2.ack || bus0.ack) acks++;
    end
    check("idle_no_ack", acks, 0);

    // RAM write/read with two wait states
    txn(1'b0, 1'b1, 16'd5, 16'hBEEF, rd, e, lat);
    check("wr5_latency", lat, 3);
    check("wr5_rdata",   {16'b0, rd}, 32'd0);
    check("wr5_err",     {31'b0, e}, 32'd0);
    txn(1'b0, 1'b0, 16'd5, 16'h0000, rd, e, lat);
    check("rd5_latency", lat, 3);
    check("rd5_rdata",   {16'b0, rd}, 32'h0000BEEF);
    check("rd5_hold",    {16'b0, bus2.rdata}, 32'h0000BEEF);

    // RAM top word, then the first address past it
    txn(1'b0, 1'b1, 16'd31, 16'hA5A5, rd, e, lat);
    txn(1'b0, 1'b0, 16'd31, 16'h0000, rd, e, lat);
    check("rd31_rdata", {16'b0, rd}, 32'h0000A5A5);
    txn(1'b0, 1'b1, 16'h0020, 16'h1111, rd, e, lat);
    check("wr32_err", {31'b0, e}, {31'b0, ERR_EN});
    txn(1'b0, 1'b0, 16'h0020, 16'h0000, rd, e, lat);
    check("rd32_rdata", {16'b0, rd}, 32'd0);

    // LED register and switch port
    txn(1'b0, 1'b1, 16'h1000, 16'h02AA, rd, e, lat);
    check("led_written", {22'b0, led2}, 32'h2AA);
    check("led_wr_rdata", {16'b0, rd}, 32'd0);
    txn(1'b0, 1'b0, 16'h1000, 16'h0000, rd, e, lat);
    check("led_readback", {16'b0, rd}, 32'h02AA);
    txn(1'b0, 1'b1, 16'h1001, 16'h0155, rd, e, lat);
    check("led_alias_led", {22'b0, led2}, 32'h2AA);
    check("led_alias_err", {31'b0, e}, {31'b0, ERR_EN});
    sw = 10'h155;
    txn(1'b0, 1'b0, 16'h3000, 16'h0000, rd, e, lat);
    check("sw_read", {16'b0, rd}, 32'h0155);

    // Unmapped read and switch-port write
    txn(1'b0, 1'b0, 16'h0040, 16'h0000, rd, e, lat);
    check("unmap_latency", lat, 3);
    check("unmap_rdata", {16'b0, rd}, 32'd0);
    check("unmap_err",   {31'b0, e}, {31'b0, ERR_EN});
    txn(1'b0, 1'b1, 16'h3000, 16'h03FF, rd, e, lat);
    check("sw_wr_err", {31'b0, e}, {31'b0, ERR_EN});
    txn(1'b0, 1'b0, 16'h3000, 16'h0000, rd, e, lat);
    check("sw_unchanged", {16'b0, rd}, 32'h0155);

    // Zero wait states: preload, then three back-to-back reads with req held high
    for (int i = 0; i < 3; i++) begin
      txn(1'b1, 1'b1, 16'(i), 16'(i + 1), rd, e, lat);
      check("w0_wr_latency", lat, 1);
    end
    @(negedge clk);
    bus0.req = 1'b1; bus0.wr = 1'b0; bus0.addr = 16'd0;
    k = 0;
    for (int edge_n = 1; edge_n <= 12 && k < 3; edge_n++) begin
      @(posedge clk); #1;
      if (bus0.ack) begin
        ack_edge[k] = edge_n;
        got[k] = bus0.rdata;
        k++;
        bus0.addr = 16'(k);
        if (k == 3) bus0.req = 1'b0;
      end
    end
    check("b2b_acks", k, 3);
    for (int i = 0; i < 3; i++) begin
      check("b2b_edge",  ack_edge[i], 2 * i + 1);
      check("b2b_rdata", {16'b0, got[i]}, 32'(i + 1));
    end
    @(posedge clk); #1;

    // Reset during WAIT aborts the write
    txn(1'b0, 1'b1, 16'd7, 16'h0777, rd, e, lat);
    @(negedge clk);
    bus2.req = 1'b1; bus2.wr = 1'b1; bus2.addr = 16'd7; bus2.wdata = 16'h1234;
    @(posedge clk); #1;
    reset_n = 1'b0;
    bus2.req = 1'b0;
    acks = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus2.ack) acks++;
    end
    check("abort_no_ack", acks, 0);
    check("abort_led",    {22'b0, led2}, 32'd0);
    check("abort_rdata",  {16'b0, bus2.rdata}, 32'd0);
    @(negedge clk) reset_n = 1'b1;
    acks = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus2.ack) acks++;
    end
    check("abort_still_idle", acks, 0);
    txn(1'b0, 1'b0, 16'd7, 16'h0000, rd, e, lat);
    check("abort_rd7", {16'b0, rd}, 32'h0777);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
